// File: rtl/fifo_out_arbiter.sv
// Round-robin N:1 arbiter with a registered output stage, merging FWFT FIFO
// outputs onto one valid/ready stream; optional per-source burst hold.
module fifo_out_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            i__data_in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ia__data_in,
  output logic [NUM_INPUTS-1:0]            o__data_in_ready,
  output logic                             o__data_out_valid,
  output logic [DATA_WIDTH-1:0]            o__data_out,
  output logic [$clog2(NUM_INPUTS)-1:0]    o__grant_idx,
  input  logic                             i__data_out_ready
);

  localparam int IW = $clog2(NUM_INPUTS);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_INPUTS - 1);

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IW-1:0]         out_idx;
  logic [IW-1:0]         ptr;
  logic [BW-1:0]         burst_cnt;

  logic                  load_en;
  logic                  has_winner;
  logic [IW-1:0]         winner;
  logic [DATA_WIDTH-1:0] win_data;

  assign load_en = !out_valid || i__data_out_ready;

  always_comb begin
    int unsigned idx;
    idx        = 0;
    has_winner = 1'b0;
    winner     = ptr;
    if (i__data_in_valid[ptr] && burst_cnt != '0 && burst_cnt < BURST_MAX) begin
      has_winner = 1'b1;
    end else begin
      // Scan ptr+1 .. ptr (wrapping), so the last granted source is lowest priority.
      for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
        idx = (32'(ptr) + k) % NUM_INPUTS;
        if (!has_winner && i__data_in_valid[IW'(idx)]) begin
          has_winner = 1'b1;
          winner     = IW'(idx);
        end
      end
    end

    win_data = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (IW'(k) == winner) win_data = ia__data_in[k*DATA_WIDTH +: DATA_WIDTH];
    end

    o__data_in_ready = '0;
    if (reset && load_en && has_winner) o__data_in_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      ptr       <= LAST_IDX;
      burst_cnt <= '0;
    end else if (load_en) begin
      if (has_winner) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_idx   <= winner;
        ptr       <= winner;
        // Saturates at MAX_BURST: a lone source streaming past its burst must
        // still yield as soon as another input becomes valid.
        if (winner == ptr && burst_cnt != '0)
          burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + BW'(1);
        else
          burst_cnt <= BW'(1);
      end else begin
        out_valid <= 1'b0;
        burst_cnt <= '0;
      end
    end
  end

  assign o__data_out_valid = out_valid;
  assign o__data_out       = out_data;
  assign o__grant_idx      = out_idx;

endmodule

// File: tb/tb_fifo_out_arbiter.sv
// Bench for fifo_out_arbiter: two configurations (4 inputs/burst 1, 3 inputs/burst 3)
// driven in lockstep and compared every cycle against a beat-level reference model.
module tb_fifo_out_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  va, rdy_a;
  logic [63:0] da;
  logic        ra, ov_a;
  logic [15:0] od_a;
  logic [1:0]  oi_a;
  logic [2:0]  vb, rdy_b;
  logic [47:0] db;
  logic        rb, ov_b;
  logic [15:0] od_b;
  logic [1:0]  oi_b;

  fifo_out_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(16), .MAX_BURST(1)) dut_a (
    .clk(clk), .reset(rst_n), .i__data_in_valid(va), .ia__data_in(da),
    .o__data_in_ready(rdy_a), .o__data_out_valid(ov_a), .o__data_out(od_a),
    .o__grant_idx(oi_a), .i__data_out_ready(ra));

  fifo_out_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(16), .MAX_BURST(3)) dut_b (
    .clk(clk), .reset(rst_n), .i__data_in_valid(vb), .ia__data_in(db),
    .o__data_in_ready(rdy_b), .o__data_out_valid(ov_b), .o__data_out(od_b),
    .o__grant_idx(oi_b), .i__data_out_ready(rb));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: per-config last grant, length of its current run of beats,
  // the output register contents, and per-input pop counts (upstream FIFO heads).
  int          nin[2] = '{4, 3};
  int          mb[2]  = '{1, 3};
  int          m_ptr[2], m_streak[2], m_oi[2];
  logic        m_ov[2];
  logic [15:0] m_od[2];
  int          cnt[2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [15:0] word(input int d, input int i);
    return {4'(i), 12'(cnt[d][i])};
  endfunction

  task automatic model_reset(input int d);
    m_ov[d] = 1'b0; m_od[d] = '0; m_oi[d] = 0; m_ptr[d] = nin[d] - 1; m_streak[d] = 0;
  endtask

  function automatic int pick(input int d, input logic [3:0] vm, input logic rdy, input logic rst_v);
    if (!rst_v || (m_ov[d] && !rdy)) return -1;
    if (vm[m_ptr[d]] && m_streak[d] >= 1 && m_streak[d] < mb[d]) return m_ptr[d];
    for (int k = 1; k <= nin[d]; k++) begin
      int j;
      j = (m_ptr[d] + k) % nin[d];
      if (vm[j]) return j;
    end
    return -1;
  endfunction

  task automatic step(input int d, input logic rdy, input logic rst_v, input int w);
    if (!rst_v) model_reset(d);
    else if (!m_ov[d] || rdy) begin
      if (w >= 0) begin
        m_od[d] = word(d, w);
        m_oi[d] = w;
        m_ov[d] = 1'b1;
        m_streak[d] = (w == m_ptr[d] && m_streak[d] >= 1) ? m_streak[d] + 1 : 1;
        m_ptr[d] = w;
        cnt[d][w]++;
      end else begin
        m_ov[d] = 1'b0;
        m_streak[d] = 0;
      end
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(input logic r, input logic [3:0] pva, input logic pra,
                       input logic [2:0] pvb, input logic prb);
    int wa, wb;
    rst_n = r; va = pva; ra = pra; vb = pvb; rb = prb;
    for (int i = 0; i < 4; i++) da[i*16 +: 16] = word(0, i);
    for (int i = 0; i < 3; i++) db[i*16 +: 16] = word(1, i);
    #1;
    wa = pick(0, pva, pra, r);
    wb = pick(1, {1'b0, pvb}, prb, r);
    check("a_ready", 32'(rdy_a), (wa < 0) ? 32'd0 : (32'd1 << wa));
    check("a_valid", 32'(ov_a), 32'(m_ov[0]));
    check("a_data",  32'(od_a), 32'(m_od[0]));
    check("a_idx",   32'(oi_a), 32'(m_oi[0]));
    check("b_ready", 32'(rdy_b), (wb < 0) ? 32'd0 : (32'd1 << wb));
    check("b_valid", 32'(ov_b), 32'(m_ov[1]));
    check("b_data",  32'(od_b), 32'(m_od[1]));
    check("b_idx",   32'(oi_b), 32'(m_oi[1]));
    step(0, pra, r, wa);
    step(1, prb, r, wb);
    @(posedge clk);
    @(negedge clk);
  endtask

  int b_seq[8] = '{0, 0, 0, 2, 2, 2, 0, 0};

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) cnt[d][i] = 0;
    rst_n = 1'b0; va = '0; vb = '0; ra = 1'b1; rb = 1'b1; da = '0; db = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    model_reset(0); model_reset(1);
    check("rst_a_valid", 32'(ov_a), 0);
    check("rst_a_data",  32'(od_a), 0);
    check("rst_a_idx",   32'(oi_a), 0);
    check("rst_b_valid", 32'(ov_b), 0);
    check("rst_a_ready", 32'(rdy_a), 0);

    // All inputs valid, downstream ready: strict rotation with no bubbles; B bursts.
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 4'hF, 1'b1, 3'b101, 1'b1);
      check("rr_valid", 32'(ov_a), 1);
      check("rr_idx",   32'(oi_a), 32'(k % 4));
      check("rr_data",  32'(od_a), 32'(((k % 4) << 12) | (k / 4)));
      check("burst_idx", 32'(oi_b), 32'(b_seq[k]));
    end

    // Input 0 drops after one beat: grant moves to 2 at once.
    cycle(1'b1, 4'hF, 1'b1, 3'b100, 1'b1);
    cycle(1'b1, 4'hF, 1'b1, 3'b001, 1'b1);
    cycle(1'b1, 4'hF, 1'b1, 3'b100, 1'b1);
    check("drop_idx", 32'(oi_b), 2);

    // Downstream stall for 5 cycles, then resume.
    for (int k = 0; k < 5; k++) cycle(1'b1, 4'hF, 1'b0, 3'b111, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'hF, 1'b1, 3'b111, 1'b1);

    // Single sources: 3, then 1 (wrapping past 0), streamed back to back.
    cycle(1'b1, 4'b1000, 1'b1, 3'b010, 1'b1);
    check("walk_idx3", 32'(oi_a), 3);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 4'b0010, 1'b1, 3'b001, 1'b1);
      check("walk_idx1", 32'(oi_a), 1);
      check("walk_valid", 32'(ov_a), 1);
    end

    // Reset while holding a beat with input 2 valid.
    cycle(1'b1, 4'b0100, 1'b0, 3'b100, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0, 3'b100, 1'b0);
    check("midrst_valid", 32'(ov_a), 0);
    cycle(1'b1, 4'b0101, 1'b1, 3'b101, 1'b1);
    check("midrst_idx", 32'(oi_a), 0);
    check("midrst_b_idx", 32'(oi_b), 0);

    // Randomized valid/ready with occasional resets.
    for (int k = 0; k < 6000; k++) begin
      cycle(($urandom % 400) != 0, 4'($urandom_range(0, 15)), ($urandom % 4) != 0,
            3'($urandom_range(0, 7)), ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
